// File: rtl/alu_issue_unit.sv
// alu_issue_unit: instruction FIFO, register file and issue/writeback FSM
// wrapped around an external combinational 8-bit ALU.
module alu_issue_unit #(
    parameter int DATA_WIDTH = 8,
    parameter int REG_COUNT  = 8,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         instr_valid,
    output logic                         instr_ready,
    input  logic [3:0]                   instr_op,
    input  logic [$clog2(REG_COUNT)-1:0] instr_rd,
    input  logic [$clog2(REG_COUNT)-1:0] instr_ra,
    input  logic [$clog2(REG_COUNT)-1:0] instr_rb,
    input  logic                         instr_use_imm,
    input  logic [DATA_WIDTH-1:0]        instr_imm,
    output logic [DATA_WIDTH-1:0]        alu_operand_a,
    output logic [DATA_WIDTH-1:0]        alu_operand_b,
    output logic [3:0]                   alu_operation,
    input  logic [DATA_WIDTH-1:0]        alu_result,
    input  logic                         alu_carry_out,
    output logic                         wb_valid,
    output logic [$clog2(REG_COUNT)-1:0] wb_rd,
    output logic [DATA_WIDTH-1:0]        wb_data,
    output logic                         carry_flag,
    output logic                         busy,
    input  logic [$clog2(REG_COUNT)-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0]        dbg_data
);

    localparam int RW = $clog2(REG_COUNT);
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(FIFO_DEPTH + 1);

    typedef struct packed {
        logic [3:0]            op;
        logic [RW-1:0]         rd;
        logic [RW-1:0]         ra;
        logic [RW-1:0]         rb;
        logic                  use_imm;
        logic [DATA_WIDTH-1:0] imm;
    } entry_t;

    typedef enum logic {IDLE, EXEC} state_t;

    state_t                state_q, state_d;
    entry_t                fifo_q [FIFO_DEPTH];
    entry_t                head;
    logic [PW-1:0]         wr_ptr, rd_ptr;
    logic [CW-1:0]         count;
    logic                  full, empty, push, pop;
    logic [RW-1:0]         rd_q;
    logic [DATA_WIDTH-1:0] regs [REG_COUNT];

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // r0 is hardwired to zero regardless of array contents
    function automatic logic [DATA_WIDTH-1:0] rf_read(input logic [RW-1:0] a);
        return (a == '0) ? '0 : regs[a];
    endfunction

    assign full        = (count == CW'(FIFO_DEPTH));
    assign empty       = (count == '0);
    assign instr_ready = !full;
    assign push        = instr_valid && !full;
    assign head        = fifo_q[rd_ptr];
    assign busy        = (state_q == EXEC) || !empty;
    assign dbg_data    = rf_read(dbg_addr);

    always_comb begin
        state_d = state_q;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (!empty) begin
                    pop     = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push) begin
            fifo_q[wr_ptr] <= '{op: instr_op, rd: instr_rd, ra: instr_ra,
                                rb: instr_rb, use_imm: instr_use_imm,
                                imm: instr_imm};
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= ptr_inc(wr_ptr);
            if (pop) rd_ptr <= ptr_inc(rd_ptr);
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (!push && pop) begin
                count <= count - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            alu_operand_a <= '0;
            alu_operand_b <= '0;
            alu_operation <= '0;
            rd_q          <= '0;
        end else if (pop) begin
            alu_operand_a <= rf_read(head.ra);
            alu_operand_b <= head.use_imm ? head.imm : rf_read(head.rb);
            alu_operation <= head.op;
            rd_q          <= head.rd;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < REG_COUNT; i++) regs[i] <= '0;
        end else if (state_q == EXEC && rd_q != '0) begin
            regs[rd_q] <= alu_result;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_valid   <= 1'b0;
            wb_rd      <= '0;
            wb_data    <= '0;
            carry_flag <= 1'b0;
        end else begin
            wb_valid <= (state_q == EXEC);
            if (state_q == EXEC) begin
                wb_rd      <= rd_q;
                wb_data    <= alu_result;
                carry_flag <= alu_carry_out;
            end
        end
    end

endmodule
